// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer constants and the entry bit layout.
// Entry layout, MSB first: {valid, done, physical_rd, old_physical_rd}.
package rob_pkg;
    localparam int TAG_WIDTH = 6;
    localparam int ROB_DEPTH = 16;
    localparam int IDX_WIDTH = $clog2(ROB_DEPTH);
    localparam int NUM_CMP   = 4;
endpackage

`ifndef ROB_PKG_FIELDS
`define ROB_PKG_FIELDS
`define ROB_ENTRY_W(tw)   (2*(tw)+2)
`define ROB_VALID(tw)     (2*(tw)+1)
`define ROB_DONE(tw)      (2*(tw))
`define ROB_PHYS_RD(tw)   (2*(tw))-1:(tw)
`define ROB_OLD_RD(tw)    (tw)-1:0
`endif

// File: rtl/reorder_buffer_if.sv
// Dispatch, completion and retirement signals between Rename/FUs and the ROB.
interface reorder_buffer_if #(
    parameter int TAG_WIDTH = rob_pkg::TAG_WIDTH,
    parameter int IDX_WIDTH = rob_pkg::IDX_WIDTH
);
    logic                 alloc_valid;
    logic [TAG_WIDTH-1:0] alloc_physical_rd;
    logic [TAG_WIDTH-1:0] alloc_old_physical_rd;
    logic                 alloc_ready;
    logic [IDX_WIDTH-1:0] alloc_index;
    logic                 complete_0_valid, complete_1_valid, complete_2_valid, complete_3_valid;
    logic [IDX_WIDTH-1:0] complete_0_index, complete_1_index, complete_2_index, complete_3_index;
    logic [TAG_WIDTH-1:0] freed_tag_1;
    logic [TAG_WIDTH-1:0] freed_tag_2;
    logic [1:0]           retire_count;
    logic [IDX_WIDTH:0]   count;
    logic                 empty;

    modport master (
        output alloc_valid, alloc_physical_rd, alloc_old_physical_rd,
        output complete_0_valid, complete_1_valid, complete_2_valid, complete_3_valid,
        output complete_0_index, complete_1_index, complete_2_index, complete_3_index,
        input  alloc_ready, alloc_index, freed_tag_1, freed_tag_2, retire_count, count, empty
    );

    modport slave (
        input  alloc_valid, alloc_physical_rd, alloc_old_physical_rd,
        input  complete_0_valid, complete_1_valid, complete_2_valid, complete_3_valid,
        input  complete_0_index, complete_1_index, complete_2_index, complete_3_index,
        output alloc_ready, alloc_index, freed_tag_1, freed_tag_2, retire_count, count, empty
    );
endinterface

// File: rtl/reorder_buffer_retire_select.sv
// Picks up to two in-order retirements starting at the head.
module rob_retire_select #(
    parameter int ROB_DEPTH = 16,
    parameter int IDX_WIDTH = 4
) (
    input  logic [IDX_WIDTH-1:0] head,
    input  logic [ROB_DEPTH-1:0] valid_vec,
    input  logic [ROB_DEPTH-1:0] done_vec,
    output logic                 r0,
    output logic                 r1,
    output logic [1:0]           retire_count,
    output logic [IDX_WIDTH-1:0] idx0,
    output logic [IDX_WIDTH-1:0] idx1
);
    assign idx0 = head;
    assign idx1 = head + IDX_WIDTH'(1);
    // head+1 may only go when head goes, keeping retirement strictly in order
    assign r0 = valid_vec[idx0] && done_vec[idx0];
    assign r1 = r0 && valid_vec[idx1] && done_vec[idx1];
    assign retire_count = 2'(r0) + 2'(r1);
endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: records renamed destinations at dispatch,
// marks completions, retires up to two per cycle and returns old tags.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ROB_DEPTH = rob_pkg::ROB_DEPTH,
    parameter int TAG_WIDTH = rob_pkg::TAG_WIDTH,
    parameter int IDX_WIDTH = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    reorder_buffer_if.slave  rob
);
    localparam int EW = `ROB_ENTRY_W(TAG_WIDTH);

    logic [EW-1:0]                       entry_q [ROB_DEPTH];
    logic [IDX_WIDTH-1:0]                head_q, tail_q;
    logic [IDX_WIDTH:0]                  count_q;
    logic [TAG_WIDTH-1:0]                freed1_q, freed2_q;
    logic [1:0]                          rcnt_q;
    logic [ROB_DEPTH-1:0]                valid_vec, done_vec;
    logic [NUM_CMP-1:0]                  cmp_vld;
    logic [NUM_CMP-1:0][IDX_WIDTH-1:0]   cmp_idx;
    logic                                r0, r1, alloc_fire;
    logic [1:0]                          rcnt;
    logic [IDX_WIDTH-1:0]                idx0, idx1;

    assign cmp_vld = {rob.complete_3_valid, rob.complete_2_valid,
                      rob.complete_1_valid, rob.complete_0_valid};
    assign cmp_idx = {rob.complete_3_index, rob.complete_2_index,
                      rob.complete_1_index, rob.complete_0_index};

    // Flatten per-entry valid/done bits for the retire selector
    always_comb begin
        valid_vec = '0;
        done_vec  = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            valid_vec[i] = entry_q[i][`ROB_VALID(TAG_WIDTH)];
            done_vec[i]  = entry_q[i][`ROB_DONE(TAG_WIDTH)];
        end
    end

    rob_retire_select #(.ROB_DEPTH(ROB_DEPTH), .IDX_WIDTH(IDX_WIDTH)) u_sel (
        .head(head_q), .valid_vec(valid_vec), .done_vec(done_vec),
        .r0(r0), .r1(r1), .retire_count(rcnt), .idx0(idx0), .idx1(idx1)
    );

    // Space is judged on registered count only; same-edge retires do not help
    assign rob.alloc_ready  = count_q < (IDX_WIDTH+1)'(ROB_DEPTH);
    assign rob.alloc_index  = tail_q;
    assign rob.count        = count_q;
    assign rob.empty        = (count_q == '0);
    assign rob.freed_tag_1  = freed1_q;
    assign rob.freed_tag_2  = freed2_q;
    assign rob.retire_count = rcnt_q;
    assign alloc_fire       = rob.alloc_valid && rob.alloc_ready;

    // Entry array, pointers, count and registered retirement outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            freed1_q <= '0;
            freed2_q <= '0;
            rcnt_q   <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) entry_q[i] <= '0;
        end else begin
            // Retired, allocated and completed entries never coincide, so order is free
            if (r0) begin
                entry_q[idx0][`ROB_VALID(TAG_WIDTH)] <= 1'b0;
                entry_q[idx0][`ROB_DONE(TAG_WIDTH)]  <= 1'b0;
            end
            if (r1) begin
                entry_q[idx1][`ROB_VALID(TAG_WIDTH)] <= 1'b0;
                entry_q[idx1][`ROB_DONE(TAG_WIDTH)]  <= 1'b0;
            end
            if (alloc_fire)
                entry_q[tail_q] <= {1'b1, 1'b0, rob.alloc_physical_rd, rob.alloc_old_physical_rd};
            for (int k = 0; k < NUM_CMP; k++)
                if (cmp_vld[k]) entry_q[cmp_idx[k]][`ROB_DONE(TAG_WIDTH)] <= 1'b1;
            head_q   <= head_q + IDX_WIDTH'(rcnt);
            tail_q   <= tail_q + IDX_WIDTH'(alloc_fire);
            count_q  <= count_q + (IDX_WIDTH+1)'(alloc_fire) - (IDX_WIDTH+1)'(rcnt);
            freed1_q <= r0 ? entry_q[idx0][`ROB_OLD_RD(TAG_WIDTH)] : '0;
            freed2_q <= r1 ? entry_q[idx1][`ROB_OLD_RD(TAG_WIDTH)] : '0;
            rcnt_q   <= rcnt;
        end
    end

`ifndef SYNTHESIS
    logic [IDX_WIDTH:0] vld_cnt;

    // Population count of valid entries for the occupancy invariant
    always_comb begin
        vld_cnt = '0;
        for (int i = 0; i < ROB_DEPTH; i++) vld_cnt = vld_cnt + (IDX_WIDTH+1)'(valid_vec[i]);
    end

    // Occupancy invariants and the no-stall dispatch contract
    always @(posedge clk) begin
        if (!reset) begin
            if (rob.alloc_valid && !rob.alloc_ready) $fatal(1, "rob: allocate while full");
            if (count_q > (IDX_WIDTH+1)'(ROB_DEPTH)) $fatal(1, "rob: count overflow");
            if (vld_cnt != count_q) $fatal(1, "rob: valid entries %0d != count %0d", vld_cnt, count_q);
        end
    end

    for (genvar k = 0; k < NUM_CMP; k++) begin : g_cmp_chk
        // A completion must target a live, not-yet-done entry
        always @(posedge clk) begin
            if (!reset && cmp_vld[k]) begin
                if (!valid_vec[cmp_idx[k]]) $fatal(1, "rob: complete port %0d on invalid entry", k);
                if (done_vec[cmp_idx[k]])   $fatal(1, "rob: complete port %0d on done entry", k);
            end
        end
        for (genvar j = k + 1; j < NUM_CMP; j++) begin : g_pair
            // Two ports never report the same entry on one edge
            always @(posedge clk) begin
                if (!reset && cmp_vld[k] && cmp_vld[j] && cmp_idx[k] == cmp_idx[j])
                    $fatal(1, "rob: complete ports %0d and %0d share an index", k, j);
            end
        end
    end

    for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_ent_chk
        // Rename hands out a fresh tag, so a real destination never equals its old mapping
        always @(posedge clk) begin
            if (!reset && valid_vec[i] && entry_q[i][`ROB_PHYS_RD(TAG_WIDTH)] != '0 &&
                entry_q[i][`ROB_PHYS_RD(TAG_WIDTH)] == entry_q[i][`ROB_OLD_RD(TAG_WIDTH)])
                $fatal(1, "rob: entry %0d new tag equals old tag", i);
        end
    end
`endif
endmodule
